fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch and address stage of the 8-bit soft MPU. It sits directly upstream of the controller.
- Holds PC, IR and MR, and drives the single memory address port (PC for instruction/operand fetch, MR for data access).
- Computes next-PC for sequential, absolute and relative jumps under the controller's JMPsel/PCload strobes.
- Feeds IR back to the controller and supplies fetch status/trace counters.

Parameters:
- ADDR_W, 8, memory address and PC/MR width.
- DATA_W, 8, memory word and IR width.
- CNT_W, 16, width of the fetched-instruction counter.

Ports:
- clkin  in  1  system clock; all registers update on rising edge.
- rst  in  1  asynchronous active-high reset.
- IRload  in  1  load IR from mem_rdata.
- MRload  in  1  load MR from mem_rdata.
- PCload  in  1  update PC per JMPsel.
- JMPsel  in  2  00 PC+1, 01 absolute (mem_rdata), 10 relative backward, 11 relative forward.
- MemInst  in  1  1: address memory with MR; 0: address with PC.
- stop  in  1  halt; freezes PC/IR/MR/counter.
- mem_rdata  in  DATA_W  asynchronous-read memory data for the current mem_addr.
- mem_addr  out  ADDR_W  memory address.
- IR  out  DATA_W  instruction register to controller.
- MR  out  ADDR_W  memory-address register.
- PC  out  ADDR_W  program counter.
- pc_wrap  out  1  sticky flag: PC+1 wrapped from all-ones to 0.
- fetch_cnt  out  CNT_W  number of IR loads since reset.
- halted  out  1  registered copy of stop.

Behaviour:
- Reset, asynchronous, asserted on rst high: PC=0, IR=0 (NOP), MR=0, pc_wrap=0, fetch_cnt=0, halted=0. Held while rst is high; reset mid-jump discards the jump.
- mem_addr is combinational: MemInst ? MR : PC. Zero latency.
- Per rising edge when not stop:
  - IRload: IR <= mem_rdata, and fetch_cnt <= fetch_cnt+1, saturating at all-ones.
  - MRload: MR <= mem_rdata[ADDR_W-1:0].
  - PCload with JMPsel=00: PC <= PC+1, modulo 2^ADDR_W. If PC was all-ones, pc_wrap <= 1.
  - PCload with JMPsel=01: PC <= mem_rdata, the operand byte at the current PC.
  - PCload with JMPsel=11: PC <= PC + zero-extended IR[2:0], modulo wrap, no pc_wrap set.
  - PCload with JMPsel=10: PC <= PC - IR[2:0], modulo wrap. An offset of 0 leaves PC unchanged.
  - PCload with JMPsel X/Z: treated as 00.
- Simultaneous IRload+PCload (fetch cycle): IR captures data at the old PC; PC increments in the same edge.
- Simultaneous IRload+MRload: both capture the same mem_rdata.
- Relative jumps always use the IR value held before the edge.
- stop high: no register changes, mem_addr still valid. halted <= stop each edge.
- Deasserting stop resumes on the next edge with no lost state.
- pc_wrap clears only on reset.

Decomposition:
- Shared package mpu_pkg: JMPsel encodings (JMP_SEQ=2'b00, JMP_ABS=2'b01, JMP_BACK=2'b10, JMP_FWD=2'b11) and ADDR_W/DATA_W defaults, so the controller and datapath use the same constants.
- One natural sub-module: pc_next_logic. It is combinational, taking PC, JMPsel, IR[2:0] and mem_rdata, and returning next_pc and a wrap indication.
- Registers stay in fetch_unit.

Test Plan:
- Reset then IRload+PCload (JMPsel=00) with mem_rdata=8'h51 -> IR=8'h51, PC=1, fetch_cnt=1, mem_addr=1.
- PC=8'h10, PCload, JMPsel=01, mem_rdata=8'hA4 -> PC=8'hA4 after one edge.
- IR=8'h65, PC=8'h20, JMPsel=11 -> PC=8'h25. IR=8'h6B, PC=8'h20, JMPsel=10 -> PC=8'h1D. IR=8'h68, JMPsel=10 -> PC unchanged.
- MRload with mem_rdata=8'h3C, then MemInst=1 -> mem_addr=8'h3C. MemInst=0 -> mem_addr=PC.
- PC=8'hFF, PCload, JMPsel=00 -> PC=0, pc_wrap=1 sticky. Then stop=1 with IRload/PCload pulsed -> PC, IR and fetch_cnt frozen, halted=1.
- Assert rst asynchronously between edges mid-jump (PC=8'h40) -> PC, IR, MR, counters immediately 0. Release -> normal fetch from address 0.

Source files
------------

// File: rtl/mpu_pkg.sv
// Constants shared by the MPU controller and datapath: jump-select encodings
// and default bus widths.
package mpu_pkg;
  localparam int MPU_ADDR_W = 8;
  localparam int MPU_DATA_W = 8;
  localparam int MPU_CNT_W  = 16;

  typedef enum logic [1:0] {
    JMP_SEQ  = 2'b00,
    JMP_ABS  = 2'b01,
    JMP_BACK = 2'b10,
    JMP_FWD  = 2'b11
  } jmp_sel_e;
endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selector. o_wrap flags only the sequential
// all-ones -> 0 rollover; relative jumps wrap silently.
module pc_next_logic
  import mpu_pkg::*;
#(
  parameter int ADDR_W = MPU_ADDR_W,
  parameter int DATA_W = MPU_DATA_W
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic [1:0]        i_jmpsel,
  input  logic [2:0]        i_ofs,
  input  logic [DATA_W-1:0] i_rdata,
  output logic [ADDR_W-1:0] o_next_pc,
  output logic              o_wrap
);

  always_comb begin
    o_next_pc = i_pc + ADDR_W'(1);
    o_wrap    = &i_pc;
    // Unknown selects fall to the default, so they behave as sequential.
    case (i_jmpsel)
      JMP_ABS: begin
        o_next_pc = i_rdata[ADDR_W-1:0];
        o_wrap    = 1'b0;
      end
      JMP_BACK: begin
        o_next_pc = i_pc - ADDR_W'(i_ofs);
        o_wrap    = 1'b0;
      end
      JMP_FWD: begin
        o_next_pc = i_pc + ADDR_W'(i_ofs);
        o_wrap    = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch / address stage: holds PC, IR, MR, drives the memory
// address and keeps fetch status counters.
module fetch_unit
  import mpu_pkg::*;
#(
  parameter int ADDR_W = MPU_ADDR_W,
  parameter int DATA_W = MPU_DATA_W,
  parameter int CNT_W  = MPU_CNT_W
) (
  input  logic              clkin,
  input  logic              rst,
  input  logic              IRload,
  input  logic              MRload,
  input  logic              PCload,
  input  logic [1:0]        JMPsel,
  input  logic              MemInst,
  input  logic              stop,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] IR,
  output logic [ADDR_W-1:0] MR,
  output logic [ADDR_W-1:0] PC,
  output logic              pc_wrap,
  output logic [CNT_W-1:0]  fetch_cnt,
  output logic              halted
);

  logic [ADDR_W-1:0] r_pc, r_mr;
  logic [DATA_W-1:0] r_ir;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_wrap, r_halted;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_wrap;

  pc_next_logic #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pc_next (
    .i_pc      (r_pc),
    .i_jmpsel  (JMPsel),
    .i_ofs     (r_ir[2:0]),
    .i_rdata   (mem_rdata),
    .o_next_pc (w_next_pc),
    .o_wrap    (w_wrap)
  );

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      r_pc     <= '0;
      r_ir     <= '0;
      r_mr     <= '0;
      r_cnt    <= '0;
      r_wrap   <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      r_halted <= stop;
      if (!stop) begin
        // IR and the relative-jump offset both see the pre-edge IR value.
        if (IRload) begin
          r_ir <= mem_rdata;
          if (~&r_cnt) r_cnt <= r_cnt + CNT_W'(1);
        end
        if (MRload) r_mr <= mem_rdata[ADDR_W-1:0];
        if (PCload) begin
          r_pc <= w_next_pc;
          if (w_wrap) r_wrap <= 1'b1;
        end
      end
    end
  end

  assign mem_addr  = MemInst ? r_mr : r_pc;
  assign IR        = r_ir;
  assign MR        = r_mr;
  assign PC        = r_pc;
  assign pc_wrap   = r_wrap;
  assign fetch_cnt = r_cnt;
  assign halted    = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// against a behavioural model with a 256-byte memory.
module tb_fetch_unit;
  logic        clkin = 1'b0;
  logic        rst, IRload, MRload, PCload, MemInst, stop;
  logic [1:0]  JMPsel;
  logic [7:0]  mem_rdata, mem_addr, IR, MR, PC;
  logic        pc_wrap, halted;
  logic [15:0] fetch_cnt;

  logic [7:0]  mem [256];
  logic [7:0]  m_pc, m_ir, m_mr;
  logic [15:0] m_cnt;
  logic        m_wrap, m_halt;
  int          total = 0, bad = 0;

  always #5 clkin = ~clkin;
  assign mem_rdata = mem[mem_addr];

  fetch_unit dut (
    .clkin(clkin), .rst(rst), .IRload(IRload), .MRload(MRload), .PCload(PCload),
    .JMPsel(JMPsel), .MemInst(MemInst), .stop(stop), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .IR(IR), .MR(MR), .PC(PC), .pc_wrap(pc_wrap),
    .fetch_cnt(fetch_cnt), .halted(halted)
  );

  task automatic model_reset();
    m_pc = 0; m_ir = 0; m_mr = 0; m_cnt = 0; m_wrap = 0; m_halt = 0;
  endtask

  // Apply one cycle of strobes at a negedge, advance the model, return at the next negedge.
  task automatic step(input logic il, ml, pl, input logic [1:0] js, input logic mi, st);
    logic [7:0] rd, oir;
    IRload = il; MRload = ml; PCload = pl; JMPsel = js; MemInst = mi; stop = st;
    #1;
    rd  = mem[mi ? m_mr : m_pc];
    oir = m_ir;
    if (!st) begin
      if (il) begin
        m_ir = rd;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      end
      if (ml) m_mr = rd;
      if (pl) begin
        if (js == 2'b01)      m_pc = rd;
        else if (js == 2'b10) m_pc = m_pc - {5'b0, oir[2:0]};
        else if (js == 2'b11) m_pc = m_pc + {5'b0, oir[2:0]};
        else begin
          if (m_pc == 8'hFF) m_wrap = 1'b1;
          m_pc = m_pc + 8'd1;
        end
      end
    end
    m_halt = st;
    @(posedge clkin);
    @(negedge clkin);
    IRload = 0; MRload = 0; PCload = 0; JMPsel = 2'b00; stop = 0;
  endtask

  task automatic test_reset();
    rst = 1; IRload = 0; MRload = 0; PCload = 0; JMPsel = 0; MemInst = 0; stop = 0;
    repeat (2) @(posedge clkin);
    @(negedge clkin); rst = 0; model_reset();
    total++; if (PC !== 8'h00)        begin bad++; $display("FAIL reset_pc got %h want 00", PC); end
    total++; if (IR !== 8'h00)        begin bad++; $display("FAIL reset_ir got %h want 00", IR); end
    total++; if (MR !== 8'h00)        begin bad++; $display("FAIL reset_mr got %h want 00", MR); end
    total++; if (fetch_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got %0d want 0", fetch_cnt); end
    total++; if ({pc_wrap, halted} !== 2'b00) begin bad++; $display("FAIL reset_flags got %b want 00", {pc_wrap, halted}); end
    total++; if (mem_addr !== 8'h00)  begin bad++; $display("FAIL reset_addr got %h want 00", mem_addr); end
  endtask

  task automatic test_fetch();
    mem[0] = 8'h51;
    step(1, 0, 1, 2'b00, 0, 0);
    total++; if (IR !== 8'h51)        begin bad++; $display("FAIL fetch_ir got %h want 51", IR); end
    total++; if (PC !== 8'h01)        begin bad++; $display("FAIL fetch_pc got %h want 01", PC); end
    total++; if (fetch_cnt !== 16'd1) begin bad++; $display("FAIL fetch_cnt got %0d want 1", fetch_cnt); end
    total++; if (mem_addr !== 8'h01)  begin bad++; $display("FAIL fetch_addr got %h want 01", mem_addr); end
  endtask

  task automatic test_abs();
    mem[8'h01] = 8'h10;
    step(0, 0, 1, 2'b01, 0, 0);
    total++; if (PC !== 8'h10) begin bad++; $display("FAIL abs1_pc got %h want 10", PC); end
    mem[8'h10] = 8'hA4;
    step(0, 0, 1, 2'b01, 0, 0);
    total++; if (PC !== 8'hA4) begin bad++; $display("FAIL abs2_pc got %h want a4", PC); end
  endtask

  task automatic test_rel();
    mem[8'hA4] = 8'h20; step(0, 0, 1, 2'b01, 0, 0);
    mem[8'h20] = 8'h65; step(1, 0, 0, 2'b00, 0, 0);
    step(0, 0, 1, 2'b11, 0, 0);
    total++; if (PC !== 8'h25) begin bad++; $display("FAIL rel_fwd got %h want 25", PC); end
    mem[8'h25] = 8'h20; step(0, 0, 1, 2'b01, 0, 0);
    mem[8'h20] = 8'h6B; step(1, 0, 0, 2'b00, 0, 0);
    step(0, 0, 1, 2'b10, 0, 0);
    total++; if (PC !== 8'h1D) begin bad++; $display("FAIL rel_back got %h want 1d", PC); end
    mem[8'h1D] = 8'h68; step(1, 0, 0, 2'b00, 0, 0);
    step(0, 0, 1, 2'b10, 0, 0);
    total++; if (PC !== 8'h1D) begin bad++; $display("FAIL rel_zero got %h want 1d", PC); end
    // IR loaded in the same edge as a forward jump: offset must come from the old IR (0x68 -> 0)
    mem[8'h1D] = 8'h07; step(1, 0, 1, 2'b11, 0, 0);
    total++; if (PC !== 8'h1D) begin bad++; $display("FAIL rel_old_ir got %h want 1d", PC); end
  endtask

  task automatic test_mr();
    mem[m_pc] = 8'h3C;
    step(0, 1, 0, 2'b00, 0, 0);
    MemInst = 1; #1;
    total++; if (mem_addr !== 8'h3C) begin bad++; $display("FAIL mr_addr got %h want 3c", mem_addr); end
    MemInst = 0; #1;
    total++; if (mem_addr !== m_pc) begin bad++; $display("FAIL pc_addr got %h want %h", mem_addr, m_pc); end
  endtask

  task automatic test_wrap_stop();
    logic [7:0] ir_s; logic [15:0] cnt_s;
    mem[m_pc] = 8'hFF; step(0, 0, 1, 2'b01, 0, 0);
    step(0, 0, 1, 2'b00, 0, 0);
    total++; if (PC !== 8'h00)  begin bad++; $display("FAIL wrap_pc got %h want 00", PC); end
    total++; if (pc_wrap !== 1) begin bad++; $display("FAIL wrap_flag got %b want 1", pc_wrap); end
    ir_s = m_ir; cnt_s = m_cnt;
    mem[8'h00] = 8'h99;
    step(1, 1, 1, 2'b00, 0, 1);
    step(1, 0, 1, 2'b01, 0, 1);
    total++; if (PC !== 8'h00)       begin bad++; $display("FAIL stop_pc got %h want 00", PC); end
    total++; if (IR !== ir_s)        begin bad++; $display("FAIL stop_ir got %h want %h", IR, ir_s); end
    total++; if (fetch_cnt !== cnt_s) begin bad++; $display("FAIL stop_cnt got %0d want %0d", fetch_cnt, cnt_s); end
    total++; if (halted !== 1)       begin bad++; $display("FAIL stop_halted got %b want 1", halted); end
    step(1, 0, 1, 2'b00, 0, 0);
    total++; if ({IR, PC} !== {8'h99, 8'h01}) begin bad++; $display("FAIL resume got %h want 9901", {IR, PC}); end
    total++; if ({pc_wrap, halted} !== 2'b10) begin bad++; $display("FAIL resume_flags got %b want 10", {pc_wrap, halted}); end
  endtask

  task automatic test_async_reset();
    mem[m_pc] = 8'h40; step(0, 0, 1, 2'b01, 0, 0);
    mem[8'h40] = 8'hC3; step(1, 1, 0, 2'b00, 0, 0);
    IRload = 1; PCload = 1; JMPsel = 2'b01;
    #2 rst = 1;
    #1;
    total++; if ({PC, IR, MR} !== 24'h0) begin bad++; $display("FAIL arst_regs got %h want 000000", {PC, IR, MR}); end
    total++; if ({fetch_cnt, pc_wrap} !== 17'h0) begin bad++; $display("FAIL arst_cnt got %h want 0", {fetch_cnt, pc_wrap}); end
    @(negedge clkin);
    IRload = 0; PCload = 0; JMPsel = 0;
    @(negedge clkin); rst = 0; model_reset();
    total++; if (PC !== 8'h00) begin bad++; $display("FAIL arst_hold got %h want 00", PC); end
    mem[8'h00] = 8'h2E;
    step(1, 0, 1, 2'b00, 0, 0);
    total++; if ({IR, PC} !== {8'h2E, 8'h01}) begin bad++; $display("FAIL arst_fetch got %h want 2e01", {IR, PC}); end
  endtask

  task automatic test_random();
    logic [1:0] js;
    for (int n = 0; n < 400; n++) begin
      js = 2'($urandom_range(0, 3));
      step(1'($urandom), 1'($urandom), 1'($urandom), js, 1'($urandom), ($urandom_range(0, 9) == 0));
      total++;
      if ({PC, IR, MR} !== {m_pc, m_ir, m_mr}) begin
        bad++; $display("FAIL rand_regs n=%0d got %h want %h", n, {PC, IR, MR}, {m_pc, m_ir, m_mr});
      end
      total++;
      if ({fetch_cnt, pc_wrap, halted} !== {m_cnt, m_wrap, m_halt}) begin
        bad++; $display("FAIL rand_status n=%0d got %h want %h", n, {fetch_cnt, pc_wrap, halted}, {m_cnt, m_wrap, m_halt});
      end
      total++;
      if (mem_addr !== (MemInst ? m_mr : m_pc)) begin
        bad++; $display("FAIL rand_addr n=%0d got %h want %h", n, mem_addr, MemInst ? m_mr : m_pc);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    test_reset();
    test_fetch();
    test_abs();
    test_rel();
    test_mr();
    test_wrap_stop();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
